// File: rtl/wb_stage.sv
// wb_stage: parametrised write-back stage between the MEM stage and the
// register-file write port.
//
// Picks one of NSRC result sources, aligns and extends load data, flags
// misaligned loads, and holds results in a 2-entry skid buffer. The buffer
// drains into the register file unless the register file stalls.
//
// Ports:
//   clk, rst       clock (rising edge), synchronous active-high reset
//   in_valid       MEM stage offers a result
//   in_ready       stage can accept this cycle (registered count only)
//   in_src         NSRC packed sources, source k at [k*DATA_W +: DATA_W]
//   in_sel         source select
//   in_ldmode      0 word, 1 byte s, 2 byte u, 3 half s, 4 half u, 5-7 word
//   in_boff        byte offset of the load address
//   in_we          instruction writes a register
//   in_waddr       destination register
//   wb_stall       register file cannot take a write this cycle
//   wb_we          register-file write enable
//   wb_addr        register-file write address (0 when empty)
//   wb_data        register-file write data (0 when empty)
//   wb_busy        buffer holds at least one entry
//   err_cnt        saturating count of misaligned loads
module wb_stage #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NSRC     = 4,
  parameter int SEL_W    = 2,
  parameter int LOAD_SRC = 1,
  parameter int FLAG_SRC = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NSRC*DATA_W-1:0]   in_src,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic [2:0]               in_ldmode,
  input  logic [1:0]               in_boff,
  input  logic                     in_we,
  input  logic [ADDR_W-1:0]        in_waddr,
  input  logic                     wb_stall,
  output logic                     wb_we,
  output logic [ADDR_W-1:0]        wb_addr,
  output logic [DATA_W-1:0]        wb_data,
  output logic                     wb_busy,
  output logic [7:0]               err_cnt
);

  typedef struct packed {
    logic              we;
    logic              err;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  // ent0 is always the head; ent1 is only meaningful when count==2.
  entry_t     ent0;
  entry_t     ent1;
  entry_t     new_ent;
  logic [1:0] count;

  logic              sel_hit;
  logic              is_load;
  logic              is_flag;
  logic [DATA_W-1:0] src_word;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic              half_mode;
  logic              word_mode;
  logic              mis_err;
  logic              push;
  logic              pop;

  // Source selection; a select beyond NSRC leaves sel_hit low and data 0.
  always_comb begin
    src_word = '0;
    sel_hit  = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      if (in_sel == SEL_W'(k)) begin
        src_word = in_src[k*DATA_W +: DATA_W];
        sel_hit  = 1'b1;
      end
    end
  end

  assign is_load = sel_hit && (in_sel == SEL_W'(LOAD_SRC));
  assign is_flag = sel_hit && (in_sel == SEL_W'(FLAG_SRC));

  always_comb begin
    ld_byte = src_word[7:0];
    case (in_boff)
      2'd0:    ld_byte = src_word[7:0];
      2'd1:    ld_byte = src_word[15:8];
      2'd2:    ld_byte = src_word[23:16];
      default: ld_byte = src_word[31:24];
    endcase
  end

  assign ld_half   = in_boff[1] ? src_word[31:16] : src_word[15:0];
  assign half_mode = (in_ldmode == 3'd3) || (in_ldmode == 3'd4);
  // Modes 0 and 5-7 all behave as a full word load.
  assign word_mode = (in_ldmode == 3'd0) || (in_ldmode > 3'd4);

  // Misalignment only matters for loads that would write a register.
  assign mis_err = is_load && in_we &&
                   ((half_mode && in_boff[0]) || (word_mode && (in_boff != 2'd0)));

  // Result formation, done at push time and stored in the entry.
  always_comb begin
    new_ent      = '0;
    new_ent.we   = in_we;
    new_ent.err  = mis_err;
    new_ent.addr = in_waddr;
    if (!sel_hit) begin
      new_ent.data = '0;
    end else if (is_flag) begin
      new_ent.data = {{(DATA_W-1){1'b0}}, src_word[0]};
    end else if (is_load) begin
      case (in_ldmode)
        3'd1:    new_ent.data = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
        3'd2:    new_ent.data = {{(DATA_W-8){1'b0}}, ld_byte};
        3'd3:    new_ent.data = {{(DATA_W-16){ld_half[15]}}, ld_half};
        3'd4:    new_ent.data = {{(DATA_W-16){1'b0}}, ld_half};
        default: new_ent.data = src_word;
      endcase
    end else begin
      new_ent.data = src_word;
    end
  end

  assign in_ready = (count < 2'd2);
  assign wb_busy  = (count != 2'd0);
  assign push     = in_valid && in_ready;
  assign pop      = wb_busy && !wb_stall;

  assign wb_addr = wb_busy ? ent0.addr : '0;
  assign wb_data = wb_busy ? ent0.data : '0;
  // The reset term keeps a write from escaping while the buffer is flushed.
  assign wb_we   = wb_busy && ent0.we && !ent0.err && (ent0.addr != '0) &&
                   !wb_stall && !rst;

  // Buffer update. A simultaneous push and pop can only happen at count==1
  // (push needs count<2, pop needs count>0), so the new entry becomes head.
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= 2'd0;
      ent0    <= '0;
      ent1    <= '0;
      err_cnt <= 8'd0;
    end else begin
      if (push && pop) begin
        ent0 <= new_ent;
      end else if (push) begin
        if (count == 2'd0) begin
          ent0 <= new_ent;
        end else begin
          ent1 <= new_ent;
        end
        count <= count + 2'd1;
      end else if (pop) begin
        ent0  <= ent1;
        ent1  <= '0;
        count <= count - 2'd1;
      end
      if (push && mis_err && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Parametrised write-back stage for the single-cycle/pipelined MIPS datapath; successor to the fixed 4-way write-data mux.
- Selects one of NSRC result sources and aligns/extends load data (byte/half/word, signed/unsigned).
- Buffers results in a 2-entry skid FIFO and drives the register-file write port with stall back-pressure.
- Sits between the MEM stage (valid/ready) and the register file write port.

Parameters:
- DATA_W, 32, datapath width (multiple of 16).
- ADDR_W, 5, register address width.
- NSRC, 4, number of result sources (>=2).
- SEL_W, 2, select width; must equal clog2(NSRC).
- LOAD_SRC, 1, source index that carries dmem data and gets load alignment.
- FLAG_SRC, 2, source index that is a flag: only bit 0 is used, zero-extended.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  MEM stage has a result.
- in_ready  out  1  stage can accept this cycle.
- in_src  in  NSRC*DATA_W  packed sources; source k is [k*DATA_W +: DATA_W].
- in_sel  in  SEL_W  source select.
- in_ldmode  in  3  0=word, 1=byte signed, 2=byte unsigned, 3=half signed, 4=half unsigned, 5-7 are treated as word.
- in_boff  in  2  byte offset (address[1:0]) of the load.
- in_we  in  1  instruction writes a register.
- in_waddr  in  ADDR_W  destination register.
- wb_stall  in  1  register file cannot take a write this cycle.
- wb_we  out  1  register-file write enable.
- wb_addr  out  ADDR_W  write address.
- wb_data  out  DATA_W  write data.
- wb_busy  out  1  buffer non-empty.
- err_cnt  out  8  saturating count of misaligned loads.

Behaviour:
- Reset (synchronous, active-high, clk only):
  - Buffer count=0 and both entries cleared.
  - in_ready=1, wb_we=0, wb_addr=0, wb_data=0, wb_busy=0, err_cnt=0.
  - Reset mid-operation discards all buffered entries; nothing is written to the register file in the reset cycle.
- Handshake and buffering:
  - in_ready = (count<2), derived from registered count only; no combinational path from wb_stall.
  - Push when in_valid & in_ready.
  - Head = oldest entry. Pop when count>0 & !wb_stall.
  - Push and pop in the same cycle: count unchanged, order preserved.
  - count==2: in_ready=0; a pop that cycle frees space only from the next cycle.
- Latency: an entry pushed at edge N appears on wb_* during cycle N+1 if the buffer was empty; wb_we is visible in that cycle.
- Outputs from the head entry:
  - wb_addr and wb_data come from the head; both are 0 when count==0.
  - wb_we = (count>0) & head.we & !head.err & (head.addr!=0) & !wb_stall.
  - wb_busy = (count>0).
- Data formation (computed at push, stored):
  - in_sel>=NSRC yields data 0.
  - sel==FLAG_SRC: data = {DATA_W-1 zeros, src[0]}.
  - sel==LOAD_SRC, byte modes: byte = word[8*boff +: 8], sign- or zero-extended to DATA_W.
  - sel==LOAD_SRC, half modes: half = word[16*boff[1] +: 16], extended to DATA_W.
  - sel==LOAD_SRC, word mode: raw word.
  - Any other source: passed through unchanged.
  - ldmode is ignored unless sel==LOAD_SRC.
- Misalignment (only when sel==LOAD_SRC and we=1):
  - Half mode with boff[0]=1, or word mode with boff!=0, sets entry.err.
  - The entry still occupies the buffer and pops normally, but wb_we stays 0.
  - err_cnt increments once at push, saturates at 255, and clears only on rst.
- Register 0 writes are always suppressed; the entry is still consumed.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> in_ready=1, wb_we=0, wb_data=0, err_cnt=0; an entry pushed during reset is not captured.
- ALU pass-through: sel=0, src0=0x1234_5678, waddr=5, we=1, no stall -> next cycle wb_we=1, wb_addr=5, wb_data=0x12345678; the following cycle wb_busy=0.
- Load extension: src1=0x80FF_7F01 with sel=1:
  - mode1, boff=3 -> 0xFFFFFF80.
  - mode2, boff=3 -> 0x00000080.
  - mode3, boff=2 -> 0xFFFF80FF.
  - mode4, boff=0 -> 0x00007F01.
- Flag source: sel=2, src2=0xFFFF_FFFE -> wb_data=0x00000000; src2=0x3 -> wb_data=0x00000001.
- Back-pressure: wb_stall=1, push 3 back-to-back entries A,B,C -> in_ready drops after B and C is held; release stall -> wb_data=A then B then C on consecutive cycles with no loss or duplication.
- Error and reg-0 handling:
  - Half load with boff=1 -> wb_we=0 and err_cnt=1.
  - 300 misaligned loads -> err_cnt=255.
  - waddr=0 with we=1 -> wb_we=0 and the buffer drains.
